// File: rtl/ifetch_unit.sv
// ----------------------------------------------------------------------------
// ifetch_unit
// Instruction fetch and issue unit for the single-cycle MIPS datapath.
// Holds the PC, fetches words from instruction memory over a req/ack
// handshake, latches each word into the IR and presents its fields to the
// control unit and datapath. The next PC is chosen on the issue handshake
// from the Branch/Jump/Zero signals returned by control and the ALU.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   imem_req/addr     fetch request and byte address (always equals PC)
//   imem_ack/rdata    memory response; only honoured while requesting
//   instr_valid       latched instruction is being presented
//   instr_ready       datapath completes the presented instruction
//   OP..jtarget       decoded IR fields
//   pc_out            PC of the presented instruction
//   Branch/Jump/Zero  next-PC controls, sampled on the issue handshake
//   halted            HALT_WORD was fetched; only reset restarts the unit
//   retired           number of completed issue handshakes (wraps)
// ----------------------------------------------------------------------------
module ifetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [5:0]  OP,
   output logic [5:0]  func,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [4:0]  shamt,
   output logic [15:0] imm16,
   output logic [25:0] jtarget,
   output logic [31:0] pc_out,
   input  logic        Branch,
   input  logic        Jump,
   input  logic        Zero,
   output logic        halted,
   output logic [31:0] retired
);

   typedef enum logic [1:0] {IDLE, REQ, ISSUE, HALT} state_t;

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt;
   logic [31:0] ir, ir_nxt;
   logic [31:0] retired_q, retired_nxt;

   // Jump beats Branch; the branch offset is the sign-extended word offset
   // added to PC+4. All additions wrap modulo 2^32.
   function automatic logic [31:0] next_pc(input logic [31:0] cur_pc,
                                           input logic [31:0] cur_ir,
                                           input logic        br,
                                           input logic        jp,
                                           input logic        zr);
      logic [31:0]        pc4;
      logic signed [31:0] boff;
      pc4  = cur_pc + 32'd4;
      boff = {{14{cur_ir[15]}}, cur_ir[15:0], 2'b00};
      if (jp)
         next_pc = {pc4[31:28], cur_ir[25:0], 2'b00};
      else if (br && zr)
         next_pc = pc4 + $unsigned(boff);
      else
         next_pc = pc4;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         pc        <= RESET_PC;
         ir        <= 32'h0000_0000;
         retired_q <= 32'h0000_0000;
      end else begin
         state     <= state_nxt;
         pc        <= pc_nxt;
         ir        <= ir_nxt;
         retired_q <= retired_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      ir_nxt      = ir;
      retired_nxt = retired_q;
      case (state)
         // one bubble after reset release before the first request
         IDLE: state_nxt = REQ;
         REQ: begin
            if (imem_ack) begin
               ir_nxt    = imem_rdata;
               state_nxt = (imem_rdata == HALT_WORD) ? HALT : ISSUE;
            end
         end
         ISSUE: begin
            if (instr_ready) begin
               pc_nxt      = next_pc(pc, ir, Branch, Jump, Zero);
               retired_nxt = retired_q + 32'd1;
               state_nxt   = REQ;
            end
         end
         HALT:    state_nxt = HALT;
         default: state_nxt = IDLE;
      endcase
   end

   assign imem_req    = (state == REQ);
   assign instr_valid = (state == ISSUE);
   assign halted      = (state == HALT);
   assign imem_addr   = pc;
   assign pc_out      = pc;
   assign retired     = retired_q;

   assign OP      = ir[31:26];
   assign rs      = ir[25:21];
   assign rt      = ir[20:16];
   assign rd      = ir[15:11];
   assign shamt   = ir[10:6];
   assign func    = ir[5:0];
   assign imm16   = ir[15:0];
   assign jtarget = ir[25:0];

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

   localparam logic [31:0] HALT  = 32'hFFFF_FFFF;
   localparam logic [31:0] PLAIN = 32'h0108_4020;
   localparam logic [31:0] BEQ   = 32'h1022_FFFE;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [5:0]  OP, func;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] imm16;
   logic [25:0] jtarget;
   logic [31:0] pc_out;
   logic        Branch = 1'b0, Jump = 1'b0, Zero = 1'b0;
   logic        halted;
   logic [31:0] retired;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_addr_q[$];
   logic [31:0] exp_word_q[$];
   logic [31:0] exp_retired = 32'h0;

   always #5 clk = ~clk;

   ifetch_unit dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .OP(OP), .func(func), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
      .imm16(imm16), .jtarget(jtarget), .pc_out(pc_out),
      .Branch(Branch), .Jump(Jump), .Zero(Zero),
      .halted(halted), .retired(retired)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      imem_ack = 1'b0;
      instr_ready = 1'b0;
      #1;
      checks++;
      if ({imem_req, instr_valid, halted} !== 3'b000) begin
         errors++;
         $display("FAIL reset_ctrl: req/valid/halted=%b required 000", {imem_req, instr_valid, halted});
      end
      checks++;
      if ({imem_addr, pc_out, retired} !== {32'h0, 32'h0, 32'h0}) begin
         errors++;
         $display("FAIL reset_regs: addr=%h pc_out=%h retired=%0d required 0/0/0", imem_addr, pc_out, retired);
      end
      checks++;
      if ({OP, rs, rt, rd, shamt, func, imm16, jtarget} !== 74'h0) begin
         errors++;
         $display("FAIL reset_fields: OP=%h func=%h imm16=%h jtarget=%h required all 0", OP, func, imm16, jtarget);
      end
      exp_addr_q.delete();
      exp_word_q.delete();
      exp_addr_q.push_back(32'h0);
      exp_retired = 32'h0;
      step();
      step();
      rst = 1'b0;
   endtask

   // Serves one fetch and one issue handshake; expected fetch addresses come
   // from the scoreboard queue, fed by the bench's own next-PC model.
   task automatic do_instr(input logic [31:0] word, input int ack_dly, input int rdy_dly,
                           input logic br, input logic jp, input logic zr);
      logic [31:0] a, w, pc4, npc;
      int n;
      n = 0;
      while (imem_req !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      checks++;
      if (imem_req !== 1'b1) begin
         errors++;
         $display("FAIL fetch_req: imem_req=%b required 1 within 20 cycles", imem_req);
         return;
      end
      a = (exp_addr_q.size() != 0) ? exp_addr_q.pop_front() : 32'hxxxx_xxxx;
      checks++;
      if (imem_addr !== a) begin
         errors++;
         $display("FAIL fetch_addr: imem_addr=%h required %h", imem_addr, a);
      end
      for (int i = 0; i < ack_dly; i++) begin
         imem_ack = 1'b0;
         imem_rdata = $urandom;
         step();
         checks++;
         if ({imem_req, imem_addr} !== {1'b1, a}) begin
            errors++;
            $display("FAIL ack_wait_hold: req=%b addr=%h required 1/%h", imem_req, imem_addr, a);
         end
      end
      imem_ack = 1'b1;
      imem_rdata = word;
      exp_word_q.push_back(word);
      step();
      imem_ack = 1'b0;
      imem_rdata = $urandom;
      w = exp_word_q.pop_front();

      if (w == HALT) begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if ({halted, imem_req, instr_valid, OP} !== {1'b1, 1'b0, 1'b0, 6'h3F}) begin
               errors++;
               $display("FAIL halt_hold: halted/req/valid=%b OP=%h required 100/3f",
                        {halted, imem_req, instr_valid}, OP);
            end
            imem_ack = 1'b1;
            instr_ready = 1'b1;
            step();
         end
         imem_ack = 1'b0;
         instr_ready = 1'b0;
         return;
      end

      checks++;
      if ({instr_valid, pc_out} !== {1'b1, a}) begin
         errors++;
         $display("FAIL issue_valid: valid=%b pc_out=%h required 1/%h", instr_valid, pc_out, a);
      end
      checks++;
      if ({OP, rs, rt, rd, shamt, func, imm16, jtarget} !==
          {w[31:26], w[25:21], w[20:16], w[15:11], w[10:6], w[5:0], w[15:0], w[25:0]}) begin
         errors++;
         $display("FAIL issue_fields: OP=%h func=%h imm16=%h jtarget=%h word %h", OP, func, imm16, jtarget, w);
      end
      for (int i = 0; i < rdy_dly; i++) begin
         instr_ready = 1'b0;
         Branch = 1'($urandom_range(1));
         Jump = 1'($urandom_range(1));
         Zero = 1'($urandom_range(1));
         imem_ack = 1'b1;
         step();
         checks++;
         if ({instr_valid, OP, rs, rt, rd, shamt, func, pc_out, retired} !==
             {1'b1, w[31:26], w[25:21], w[20:16], w[15:11], w[10:6], w[5:0], a, exp_retired}) begin
            errors++;
            $display("FAIL ready_stall_hold: valid=%b OP=%h func=%h pc_out=%h retired=%0d required 1/%h/%h/%h/%0d",
                     instr_valid, OP, func, pc_out, retired, w[31:26], w[5:0], a, exp_retired);
         end
      end
      imem_ack = 1'b0;
      instr_ready = 1'b1;
      Branch = br;
      Jump = jp;
      Zero = zr;
      pc4 = a + 32'd4;
      if (jp)
         npc = {pc4[31:28], w[25:0], 2'b00};
      else if (br && zr)
         npc = pc4 + {{14{w[15]}}, w[15:0], 2'b00};
      else
         npc = pc4;
      exp_addr_q.push_back(npc);
      exp_retired = exp_retired + 32'd1;
      step();
      instr_ready = 1'b0;
      Branch = 1'($urandom_range(1));
      Jump = 1'($urandom_range(1));
      Zero = 1'($urandom_range(1));
      checks++;
      if (retired !== exp_retired) begin
         errors++;
         $display("FAIL retired_count: retired=%0d required %0d", retired, exp_retired);
      end
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if (imem_req !== 1'b0) begin
         errors++;
         $display("FAIL idle_bubble: imem_req=%b required 0", imem_req);
      end
      imem_ack = 1'b1;
      imem_rdata = 32'h1234_5678;
      step();
      imem_ack = 1'b0;
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
         errors++;
         $display("FAIL first_req: req=%b addr=%h required 1/00000000", imem_req, imem_addr);
      end
      do_instr(32'h0000_0020, 0, 0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_sequential();
      do_instr(PLAIN, 0, 0, 1'b0, 1'b0, 1'b0);
      do_instr(32'h8C22_0004, 0, 0, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({retired, imem_addr} !== {32'd3, 32'h0000_000C}) begin
         errors++;
         $display("FAIL sequential: retired=%0d addr=%h required 3/0000000c", retired, imem_addr);
      end
   endtask

   task automatic test_branch();
      do_instr(PLAIN, 0, 0, 1'b0, 1'b0, 1'b0);
      do_instr(BEQ, 0, 0, 1'b1, 1'b0, 1'b1);
      checks++;
      if (imem_addr !== 32'h0000_000C) begin
         errors++;
         $display("FAIL branch_taken: addr=%h required 0000000c", imem_addr);
      end
      do_instr(PLAIN, 0, 0, 1'b0, 1'b0, 1'b0);
      do_instr(BEQ, 0, 0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (imem_addr !== 32'h0000_0014) begin
         errors++;
         $display("FAIL branch_not_taken: addr=%h required 00000014", imem_addr);
      end
   endtask

   task automatic test_jump();
      for (int k = 0; k < 3; k++) begin
         do_instr({6'h02, 26'h3FF_FFFF}, 0, 0, 1'b0, 1'b1, 1'b0);
         do_instr(PLAIN, 0, 0, 1'b0, 1'b0, 1'b0);
      end
      do_instr({6'h02, 26'h000_0010}, 0, 0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (imem_addr !== 32'h3000_0040) begin
         errors++;
         $display("FAIL jump_region: addr=%h required 30000040", imem_addr);
      end
      do_instr({6'h02, 26'h000_0100}, 0, 0, 1'b1, 1'b1, 1'b1);
      checks++;
      if (imem_addr !== 32'h3000_0400) begin
         errors++;
         $display("FAIL jump_priority: addr=%h required 30000400", imem_addr);
      end
   endtask

   task automatic test_stalls();
      logic [31:0] r0;
      r0 = retired;
      do_instr(PLAIN, 3, 2, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({retired, imem_addr} !== {r0 + 32'd1, 32'h3000_0404}) begin
         errors++;
         $display("FAIL stall_retire: retired=%0d addr=%h required %0d/30000404", retired, imem_addr, r0 + 32'd1);
      end
   endtask

   task automatic test_halt_reset();
      do_instr(HALT, 1, 0, 1'b0, 1'b0, 1'b0);
      apply_reset();
      step();
      // request cycle with an ack that coincides with reset: must be dropped
      imem_ack = 1'b1;
      imem_rdata = 32'hAC22_0008;
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({imem_req, halted, imem_addr} !== {1'b0, 1'b0, 32'h0}) begin
         errors++;
         $display("FAIL reset_abort_now: req=%b halted=%b addr=%h required 0/0/00000000", imem_req, halted, imem_addr);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({OP, imm16, instr_valid, retired} !== {6'h00, 16'h0000, 1'b0, 32'h0}) begin
         errors++;
         $display("FAIL reset_abort_ir: OP=%h imm16=%h valid=%b retired=%0d required 0/0/0/0", OP, imm16, instr_valid, retired);
      end
      imem_ack = 1'b0;
      rst = 1'b0;
      exp_addr_q.delete();
      exp_word_q.delete();
      exp_addr_q.push_back(32'h0);
      exp_retired = 32'h0;
      do_instr(32'h0000_0020, 0, 0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_branch();
      test_jump();
      test_stalls();
      test_halt_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch and issue unit for the single-cycle MIPS datapath.
- Holds the PC and fetches words from instruction memory over a req/ack handshake.
- Latches each fetched word and drives its OP/func and other fields to the control unit and datapath.
- Computes the next PC from the Branch/Jump/Zero signals returned by the control unit and ALU on each issue handshake.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  byte address of the fetch; equals PC.
- imem_ack  input  1  memory has imem_rdata valid this cycle.
- imem_rdata  input  32  fetched instruction word.
- instr_valid  output  1  latched instruction is presented for execution.
- instr_ready  input  1  datapath completes the presented instruction this cycle.
- OP  output  6  IR[31:26].
- func  output  6  IR[5:0].
- rs  output  5  IR[25:21].
- rt  output  5  IR[20:16].
- rd  output  5  IR[15:11].
- shamt  output  5  IR[10:6].
- imm16  output  16  IR[15:0].
- jtarget  output  26  IR[25:0].
- pc_out  output  32  PC of the presented instruction.
- Branch  input  1  from control unit, sampled on issue handshake.
- Jump  input  1  from control unit, sampled on issue handshake.
- Zero  input  1  ALU zero flag, sampled on issue handshake.
- halted  output  1  HALT_WORD fetched; unit stopped.
- retired  output  32  count of completed issue handshakes.

Behaviour:
- Reset (async, immediate): PC=RESET_PC, IR=0, state=IDLE, imem_req=0, instr_valid=0, halted=0, retired=0. All IR fields are therefore 0.
- imem_addr=PC at all times; pc_out=PC.
- States: IDLE, REQ, ISSUE, HALT.
- IDLE: imem_req=0. Next cycle -> REQ unconditionally (one bubble after reset release).
- REQ: imem_req=1, PC stable.
  - imem_ack=1 -> IR<=imem_rdata, then ISSUE, or HALT if imem_rdata==HALT_WORD.
  - Ack may arrive in the first REQ cycle (zero-wait memory), so the minimum fetch is 1 cycle.
  - imem_ack is ignored in every state other than REQ.
- ISSUE: instr_valid=1, IR fields stable. Wait for instr_ready=1. On the handshake edge:
  - pc4 = PC+4, mod 2^32 (wrap from 32'hFFFF_FFFC to 0 is legal).
  - If Jump=1: PC <= {pc4[31:28], jtarget, 2'b00}. Jump takes priority over Branch.
  - Else if Branch&Zero: PC <= pc4 + ({{14{imm16[15]}}, imm16, 2'b00}).
  - Else: PC <= pc4.
  - retired <= retired+1, wrapping at 2^32.
  - Next state: REQ.
- Branch/Jump/Zero are don't-care except on the ISSUE handshake cycle.
- HALT: imem_req=0, instr_valid=0, halted=1. IR keeps HALT_WORD. Only rst exits.
- Throughput: 2 cycles per instruction with zero-wait memory and instr_ready tied high.
- Reset asserted mid-REQ or mid-ISSUE aborts the operation. An outstanding ack in the reset cycle is dropped; no IR or PC update occurs.
- PC[1:0] stays 00 by construction (RESET_PC must be word-aligned).

Test Plan:
- Reset/first fetch: release rst, memory acks in the same cycle with 32'h0000_0020. Required: imem_req=0 in cycle 1, then 1 with imem_addr=0; next cycle instr_valid=1, OP=0, func=6'h20.
- Sequential flow: three non-branch instructions, instr_ready=1, Branch=Jump=0. Required: imem_addr 0, 4, 8 in successive REQ states; retired=3.
- Taken branch: PC=0x10, imm16=16'hFFFE, Branch=1, Zero=1 at handshake. Required: next imem_addr=0x0C. With Zero=0, next imem_addr=0x14.
- Jump: PC=0x3000_0040, jtarget=26'h0000100, Jump=1 and Branch=1 together. Required: next imem_addr=0x3000_0400 (Jump wins).
- Stalls: ack delayed 3 cycles, then instr_ready low for 2 cycles. Required: imem_req and imem_addr held through the ack delay; instr_valid and fields held through the ready stall; retired increments once.
- Halt/reset: fetch 32'hFFFF_FFFF. Required: halted=1, imem_req=0, instr_valid=0 permanently. Then assert rst mid-halt. Required: immediate halted=0, PC=RESET_PC, retired=0.
